// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS controller FSM with a MEM-wait watchdog and a sticky halt on illegal code.
// Build option MC_CTRL_PERF_EN adds retired-instruction and memory-stall counters.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  fc,
  input  logic [4:0]  rt,
  input  logic        br_e,
  input  logic        br_gez,
  input  logic        mem_ready,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RegWr,
  output logic        MemWr,
  output logic        mem_req,
  output logic        ALUSrc1,
  output logic        ALUSrc2,
  output logic [2:0]  ALUOp,
  output logic [1:0]  ExtOp,
  output logic [2:0]  nPC_sel,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        lb,
  output logic        sb,
  output logic [2:0]  state,
  output logic        halted
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
`endif
);

  // state | meaning: FETCH ir load + pc+4, DECODE j/jal, EXE alu/branch, MEM dm wait, WB reg write, HALT sticky error
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t            cur, nxt;
  logic [CNT_W-1:0]  wdog;
  logic              is_r, is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_lb, is_sw, is_sb;
  logic              is_beq, is_bgez, is_j, is_jal, is_load, is_store, is_mem, is_alu, legal;
  logic [2:0]        alu_op;
  logic [1:0]        ext_op;
  logic              alu_src2;

  assign is_r     = (op == 6'b000000);
  assign is_addu  = is_r && (fc == 6'b100001);
  assign is_subu  = is_r && (fc == 6'b100011);
  assign is_jr    = is_r && (fc == 6'b001000);
  assign is_ori   = (op == 6'b001101);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_lb    = (op == 6'b100000);
  assign is_sw    = (op == 6'b101011);
  assign is_sb    = (op == 6'b101000);
  assign is_beq   = (op == 6'b000100);
  assign is_bgez  = (op == 6'b000001) && (rt == 5'b00001);
  assign is_j     = (op == 6'b000010);
  assign is_jal   = (op == 6'b000011);
  assign is_load  = is_lw | is_lb;
  assign is_store = is_sw | is_sb;
  assign is_mem   = is_load | is_store;
  assign is_alu   = is_addu | is_subu | is_ori | is_lui;
  assign legal    = is_alu | is_mem | is_jr | is_beq | is_bgez | is_j | is_jal;

  // ALU selects are driven from EXE through WB so a datapath without an ALUOut latch still sees a stable result
  always_comb begin
    alu_op   = 3'd0;
    ext_op   = 2'd0;
    alu_src2 = 1'b0;
    if (is_subu || is_beq) begin
      alu_op = 3'd1;
    end else if (is_ori) begin
      alu_op   = 3'd2;
      alu_src2 = 1'b1;
    end else if (is_lui) begin
      alu_op   = 3'd3;
      ext_op   = 2'd2;
      alu_src2 = 1'b1;
    end else if (is_mem) begin
      ext_op   = 2'd1;
      alu_src2 = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur  <= S_FETCH;
      wdog <= '0;
    end else begin
      cur <= nxt;
      if (cur != S_MEM)   wdog <= '0;
      else if (!mem_ready) wdog <= wdog + 1'b1;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (!legal)              nxt = S_HALT;
        else if (is_j || is_jal) nxt = S_FETCH;
        else                     nxt = S_EXE;
      end
      S_EXE: begin
        if (is_alu)      nxt = S_WB;
        else if (is_mem) nxt = S_MEM;
        else             nxt = S_FETCH;
      end
      S_MEM: begin
        if (mem_ready)            nxt = is_load ? S_WB : S_FETCH;
        else if (wdog == WD_LAST) nxt = S_HALT;
      end
      S_WB:     nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      default:  nxt = S_HALT;
    endcase
  end

  // Gating on reset makes every strobe drop combinationally with the async reset, even mid-MEM
  always_comb begin
    PCWr     = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    MemWr    = 1'b0;
    mem_req  = 1'b0;
    ALUSrc1  = 1'b0;
    ALUSrc2  = 1'b0;
    ALUOp    = 3'd0;
    ExtOp    = 2'd0;
    nPC_sel  = 3'd0;
    RegDst   = 2'd0;
    MemtoReg = 2'd0;
    lb       = 1'b0;
    sb       = 1'b0;
    if (reset) begin
      case (cur)
        S_FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
        S_DECODE: begin
          if (is_j || is_jal) begin
            PCWr    = 1'b1;
            nPC_sel = 3'd2;
          end
          if (is_jal) begin
            RegWr    = 1'b1;
            RegDst   = 2'd2;
            MemtoReg = 2'd2;
          end
        end
        S_EXE: begin
          ALUSrc2 = alu_src2;
          ALUOp   = alu_op;
          ExtOp   = ext_op;
          if (is_beq) begin
            PCWr    = br_e;
            nPC_sel = 3'd1;
          end else if (is_bgez) begin
            PCWr    = br_gez;
            nPC_sel = 3'd4;
          end else if (is_jr) begin
            PCWr    = 1'b1;
            nPC_sel = 3'd3;
          end
        end
        S_MEM: begin
          ALUSrc2 = alu_src2;
          ALUOp   = alu_op;
          ExtOp   = ext_op;
          mem_req = 1'b1;
          MemWr   = is_store;
          lb      = is_lb;
          sb      = is_sb;
        end
        S_WB: begin
          ALUSrc2  = alu_src2;
          ALUOp    = alu_op;
          ExtOp    = ext_op;
          RegWr    = 1'b1;
          RegDst   = is_r ? 2'd1 : 2'd0;
          MemtoReg = is_load ? 2'd1 : 2'd0;
          lb       = is_lb;
        end
        default: ;
      endcase
    end
  end

  assign state  = cur;
  assign halted = (cur == S_HALT);

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if ((cur != S_HALT) && (nxt == S_FETCH)) instr_cnt <= instr_cnt + 32'd1;
      if ((cur == S_MEM) && !mem_ready)        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
